// File: rtl/stack_pkg.sv
// stack_pkg: shared widths, default geometry and FSM encoding for stack_unit.
`default_nettype none

package stack_pkg;

  localparam int ADDR_W            = 5;
  localparam int DATA_W            = 8;
  localparam int CNT_W             = 4;
  localparam int STACK_BASE_DEF    = 16;
  localparam int STACK_DEPTH_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stack_ptr.sv
// stack_ptr: occupancy counter (doubles as the stack pointer).
// It saturates at 0 and DEPTH and has a synchronous active-low clear.
`default_nettype none

module stack_ptr
  import stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != DEPTH_C)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);

endmodule

`default_nettype wire

// File: rtl/stack_unit.sv
// stack_unit: push/pop/tos sequencer in front of the 32x8 data memory.
// It drives registered address/writeData, captures readData into popData and pulses done.
`default_nettype none

module stack_unit
  import stack_pkg::*;
#(
  parameter int STACK_BASE  = STACK_BASE_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic [DATA_W-1:0] pushData,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] popData,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(STACK_BASE);

  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic              is_pop_q, is_pop_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] popdata_q, popdata_d;
  logic              inc, dec;
  logic [2:0]        cmd;

  assign cmd = {push, pop, tos};

  stack_ptr #(
    .DEPTH (STACK_DEPTH)
  ) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (inc),
    .dec_i   (dec),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    is_pop_d  = is_pop_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    popdata_d = popdata_q;
    inc       = 1'b0;
    dec       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd != 3'b000) begin
          if ((cmd == 3'b100) && !full) begin
            wdata_d   = pushData;
            address_d = BASE_ADDR + ADDR_W'(count);
            state_d   = ST_WRITE;
          end else if (((cmd == 3'b010) || (cmd == 3'b001)) && !empty) begin
            is_pop_d  = pop;
            address_d = BASE_ADDR + ADDR_W'(count) - 1'b1;
            state_d   = ST_READ;
          end else begin
            // Illegal command: no memory access, straight to the done pulse.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        inc     = 1'b1;
        state_d = ST_DONE;
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        popdata_d = readData;
        dec       = is_pop_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      err_q     <= 1'b0;
      is_pop_q  <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      popdata_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      is_pop_q  <= is_pop_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      popdata_q <= popdata_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign memwrite  = (state_q == ST_WRITE);
  assign memread   = (state_q == ST_READ) || (state_q == ST_CAPTURE);
  assign address   = address_q;
  assign writeData = wdata_q;
  assign popData   = popdata_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed checks of stack_unit against a 32x8 memory with registered read.
`default_nettype none

module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0, pop = 1'b0, tos = 1'b0;
  logic [7:0] pushData = 8'h00;
  logic       ready, done, err, empty, full, memread, memwrite;
  logic [7:0] popData, writeData, readData;
  logic [3:0] count;
  logic [4:0] address;

  logic [7:0] mem [0:31];
  int checks = 0;
  int errors = 0;
  int wr_strobes = 0;
  int a24_hits = 0;
  int both_hits = 0;

  always #5 clk = ~clk;

  stack_unit dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .tos       (tos),
    .pushData  (pushData),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .popData   (popData),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .memread   (memread),
    .memwrite  (memwrite),
    .address   (address),
    .writeData (writeData),
    .readData  (readData)
  );

  // Memory model: write on memwrite, registered read (data valid the cycle after address).
  always @(posedge clk) begin
    if (memwrite) mem[address] <= writeData;
    readData <= mem[address];
  end

  always @(negedge clk) begin
    if (memwrite) wr_strobes++;
    if ((memread || memwrite) && address == 5'd24) a24_hits++;
    if (memread && memwrite) both_hits++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Presents a command for one edge; returns at the negedge of cycle k+1.
  task automatic issue(input logic p, input logic o, input logic t, input logic [7:0] d);
    @(negedge clk);
    push = p; pop = o; tos = t; pushData = d;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; tos = 1'b0;
  endtask

  task automatic push_quiet(input logic [7:0] d);
    issue(1'b1, 1'b0, 1'b0, d);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; push = 1'b1; pop = 1'b1; pushData = 8'hFF;
    repeat (3) @(negedge clk);
    push = 1'b0; pop = 1'b0;
    checks++; if ({ready, done, err, memread, memwrite, empty, full} !== 7'b1000010) begin
      errors++; $display("FAIL reset_flags: got %b expected 1000010", {ready, done, err, memread, memwrite, empty, full}); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if ({address, writeData, popData} !== 21'd0) begin
      errors++; $display("FAIL reset_regs: got addr=%h wd=%h pd=%h expected all 0", address, writeData, popData); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", ready); end
  endtask

  task automatic test_push();
    issue(1'b1, 1'b0, 1'b0, 8'h39);
    checks++; if ({memwrite, memread, ready, done} !== 4'b1000) begin
      errors++; $display("FAIL push_k1_strobes: got %b expected 1000", {memwrite, memread, ready, done}); end
    checks++; if (address !== 5'd16) begin errors++; $display("FAIL push_address: got %0d expected 16", address); end
    checks++; if (writeData !== 8'h39) begin errors++; $display("FAIL push_writeData: got %h expected 39", writeData); end
    @(negedge clk);
    checks++; if ({done, err, memwrite} !== 3'b100) begin
      errors++; $display("FAIL push_k2_done: got %b expected 100", {done, err, memwrite}); end
    checks++; if (count !== 4'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL push_count: got count=%0d empty=%b expected 1/0", count, empty); end
    @(negedge clk);
    checks++; if ({ready, done} !== 2'b10) begin errors++; $display("FAIL push_k3_ready: got %b expected 10", {ready, done}); end
    checks++; if (mem[16] !== 8'h39) begin errors++; $display("FAIL push_mem16: got %h expected 39", mem[16]); end
  endtask

  task automatic test_pop();
    push_quiet(8'h4F);
    issue(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if ({memread, memwrite} !== 2'b10 || address !== 5'd17) begin
      errors++; $display("FAIL pop_k1_read: got rd/wr=%b addr=%0d expected 10/17", {memread, memwrite}, address); end
    @(negedge clk);
    checks++; if ({memread, done} !== 2'b10 || address !== 5'd17) begin
      errors++; $display("FAIL pop_k2_capture: got rd/done=%b addr=%0d expected 10/17", {memread, done}, address); end
    @(negedge clk);
    checks++; if ({done, err, memread} !== 3'b100) begin
      errors++; $display("FAIL pop_k3_done: got %b expected 100", {done, err, memread}); end
    checks++; if (popData !== 8'h4F) begin errors++; $display("FAIL pop_data: got %h expected 4f", popData); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL pop_count: got %0d expected 1", count); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL pop_k4_ready: got %b expected 1", ready); end
  endtask

  task automatic test_tos();
    do_reset();
    push_quiet(8'h0E);
    for (int n = 0; n < 2; n++) begin
      issue(1'b0, 1'b0, 1'b1, 8'h00);
      checks++; if (memread !== 1'b1 || address !== 5'd16) begin
        errors++; $display("FAIL tos%0d_read: got rd=%b addr=%0d expected 1/16", n, memread, address); end
      repeat (2) @(negedge clk);
      checks++; if (done !== 1'b1 || err !== 1'b0 || popData !== 8'h0E) begin
        errors++; $display("FAIL tos%0d_done: got done=%b err=%b pd=%h expected 1/0/0e", n, done, err, popData); end
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL tos%0d_count: got %0d expected 1", n, count); end
      @(negedge clk);
    end
  endtask

  task automatic test_full();
    int wr0, a0;
    do_reset();
    for (int i = 0; i < 8; i++) push_quiet(8'h10 + 8'(i));
    checks++; if (count !== 4'd8 || full !== 1'b1) begin
      errors++; $display("FAIL full_flag: got count=%0d full=%b expected 8/1", count, full); end
    wr0 = wr_strobes; a0 = a24_hits;
    issue(1'b1, 1'b0, 1'b0, 8'hAA);
    checks++; if ({done, err, memwrite} !== 3'b110) begin
      errors++; $display("FAIL overflow_k1: got done/err/wr=%b expected 110", {done, err, memwrite}); end
    checks++; if (address !== 5'd23) begin errors++; $display("FAIL overflow_addr_hold: got %0d expected 23", address); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || count !== 4'd8 || done !== 1'b0) begin
      errors++; $display("FAIL overflow_k2: got ready=%b count=%0d done=%b expected 1/8/0", ready, count, done); end
    checks++; if (wr_strobes != wr0 || a24_hits != a0) begin
      errors++; $display("FAIL overflow_nomem: got %0d writes %0d addr24 hits expected 0/0", wr_strobes - wr0, a24_hits - a0); end
    issue(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    checks++; if (popData !== 8'h17 || count !== 4'd7 || full !== 1'b0) begin
      errors++; $display("FAIL full_pop: got pd=%h count=%0d full=%b expected 17/7/0", popData, count, full); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    do_reset();
    issue(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if ({done, err, memread} !== 3'b110 || count !== 4'd0 || popData !== 8'h00) begin
      errors++; $display("FAIL underflow: got done/err/rd=%b count=%0d pd=%h expected 110/0/00", {done, err, memread}, count, popData); end
    @(negedge clk);
    push_quiet(8'h5A);
    issue(1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    issue(1'b1, 1'b1, 1'b0, 8'hC3);
    checks++; if ({done, err, memread, memwrite} !== 4'b1100) begin
      errors++; $display("FAIL pushpop_k1: got %b expected 1100", {done, err, memread, memwrite}); end
    checks++; if (count !== 4'd1 || popData !== 8'h5A) begin
      errors++; $display("FAIL pushpop_state: got count=%0d pd=%h expected 1/5a", count, popData); end
    @(negedge clk);
    checks++; if ({ready, err} !== 2'b10) begin errors++; $display("FAIL pushpop_k2: got ready/err=%b expected 10", {ready, err}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(1'b1, 1'b0, 1'b0, 8'hA1);
    pop = 1'b1;
    repeat (2) @(negedge clk);
    pop = 1'b0;
    checks++; if (ready !== 1'b1 || count !== 4'd1 || done !== 1'b0) begin
      errors++; $display("FAIL ignored_busy: got ready=%b count=%0d done=%b expected 1/1/0", ready, count, done); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || memread !== 1'b0) begin
      errors++; $display("FAIL not_queued: got ready=%b rd=%b expected 1/0", ready, memread); end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (memread !== 1'b1) begin errors++; $display("FAIL midrst_in_read: got rd=%b expected 1", memread); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if ({ready, done, memread} !== 3'b100 || count !== 4'd0) begin
      errors++; $display("FAIL midrst_abort: got ready/done/rd=%b count=%0d expected 100/0", {ready, done, memread}, count); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL midrst_nodone: got done=%b ready=%b expected 0/1", done, ready); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    test_reset();
    test_push();
    test_pop();
    test_tos();
    test_full();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    checks++; if (both_hits != 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both_hits); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stack_unit.md
# stack_unit

Stack controller for the multi-cycle MIPS-with-stack datapath, sitting directly upstream of the 32×8 data memory. It accepts push, pop and top-of-stack commands from the main controller and keeps the stack pointer. It sequences the memory's `memread`, `memwrite`, `address` and `writeData` inputs and captures `readData` into a result register. It reports completion with a one-cycle `done` pulse.

## Interface
- `STACK_BASE`, default 16: first memory address of the stack region. Keeps the stack clear of the program (0..8) and data (25..29) areas.
- `STACK_DEPTH`, default 8: number of 8-bit slots. `STACK_BASE + STACK_DEPTH` must be ≤ 32.
- `clk` input, 1: the only clock. Everything updates on its rising edge.
- `rst` input, 1: reset, synchronous and active-low.
- `push` input, 1: push command. Sampled only while `ready` = 1.
- `pop` input, 1: pop command. Removes the top entry and returns it.
- `tos` input, 1: read the top entry without removing it.
- `pushData` input, 8: value to push, latched on command accept.
- `ready` output, 1: block is idle and will accept a command this cycle.
- `done` output, 1: one-cycle pulse when a command completes.
- `err` output, 1: valid with `done`. Command was illegal (overflow, underflow, or more than one command bit set).
- `popData` output, 8: last value returned by `pop` or `tos`.
- `count` output, 4: number of occupied slots (0..`STACK_DEPTH`).
- `empty` / `full` outputs, 1 each: `count` = 0 / `count` = `STACK_DEPTH`.
- `memread`, `memwrite` outputs, 1 each: drive the memory strobes.
- `address` output, 5: drives the memory address.
- `writeData` output, 8: drives the memory write data.
- `readData` input, 8: memory read data. Valid in the cycle after `memread` and `address` become stable.

## Operation
- Stack grows upward. `sp` = `count` is the next free slot. The top entry is at `STACK_BASE + sp - 1`.
- FSM states:
  - IDLE (`ready` = 1)
  - WRITE
  - READ
  - CAPTURE
  - DONE (`done` = 1)
- In IDLE, a cycle where any command bit is 1 is an accept:
  - Exactly `push`, not full: latch `pushData` → WRITE.
  - Exactly `pop` or `tos`, not empty: latch the operation → READ.
  - Anything else (two or more bits set, push while full, pop/tos while empty): set error flag → DONE. No memory strobe, `sp` and `popData` unchanged.
- WRITE: `memwrite` = 1, `address` = `STACK_BASE + sp`, `writeData` = latched data. `sp` increments at the end of the cycle → DONE.
- READ: `memread` = 1, `address` = `STACK_BASE + sp - 1` → CAPTURE.
- CAPTURE: `memread` and `address` held. `popData` ← `readData` at the end of the cycle. `sp` decrements only for `pop` → DONE.
- DONE: `done` = 1; `err` = error flag, which is then cleared → IDLE.
- `memread` and `memwrite` are never 1 in the same cycle. Both are 0 in IDLE and DONE.
- `address` and `writeData` are registered and hold their last value outside WRITE/READ/CAPTURE.
- Address arithmetic is 5-bit and never wraps: the full/empty checks guarantee the address stays inside the stack region.

## Timing
- Accept at edge k (IDLE cycle with a command). `ready` = 0 from cycle k+1 until IDLE is re-entered.
- `push`: WRITE in cycle k+1, `done` in k+2, `ready` = 1 in k+3. `count` and `full` show the new value in k+2.
- `pop` / `tos`: READ in k+1, CAPTURE in k+2, `done` in k+3 with `popData` already valid, `ready` in k+4.
- Illegal command: `done` = 1 and `err` = 1 in k+1, `ready` in k+2.
- Commands presented while `ready` = 0 are ignored and are not queued.
- Reset (`rst` = 0 at an edge) forces IDLE and applies these output values:
  - `sp` = 0, `count` = 0, `empty` = 1, `full` = 0
  - `ready` = 1
  - `done` = 0, `err` = 0
  - `memread` = 0, `memwrite` = 0
  - `address` = 0, `writeData` = 0, `popData` = 0
- Reset mid-operation aborts the command. No `done` pulse is produced. A WRITE cycle that coincides with the reset edge may already have reached memory, but `sp` is reset regardless.

## Structure
- Shared package/include `stack_pkg`:
  - FSM state encodings (3-bit)
  - `STACK_BASE` and `STACK_DEPTH` defaults
  - memory address and data width constants (5, 8)
- One natural sub-module, `stack_ptr`: up/down counter with `inc`, `dec` and synchronous active-low clear. It outputs `count`, `empty` and `full`. The FSM and the memory-port registers stay in `stack_unit`.

## Test plan
- Reset, then push 8'h39 → WRITE at address 16 with `writeData` 8'h39. `done` at k+2, `count` = 1, `err` = 0.
- Push 8'h39, then 8'h4F, then pop → `memread` at address 17 for two cycles. `popData` = 8'h4F with `done` at k+3; `count` = 1.
- `tos` after a single push of 8'h0E → `popData` = 8'h0E, `count` stays 1. A second `tos` returns 8'h0E again.
- Eight pushes, then a ninth push → `full` = 1. Ninth push gives `done` and `err` at k+1, no `memwrite`, address 24 never driven.
- Pop on an empty stack, and push+pop asserted together → each gives `err` = 1 at k+1, with `count` and `popData` unchanged.
- Assert `rst` = 0 during the READ of a pop → no `done`; next cycle `ready` = 1, `count` = 0, `memread` = 0.
